// File: rtl/mlb_pkg.sv
// Shared constants and encodings for the multiple-level-buffer controller.
package mlb_pkg;

   localparam int unsigned NUM_SLOTS = 32;
   localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS);
   localparam int unsigned CNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE,
      SEQ,
      DONE
   } seq_state_t;

   typedef enum logic [1:0] {
      ACC_NONE,
      ACC_RD,
      ACC_WR
   } acc_t;

endpackage

// File: rtl/mlb_ctrl_if.sv
// Requester handshakes and buffer drive of the MLB controller.
interface mlb_ctrl_if;
   import mlb_pkg::*;

   logic              wr_req;
   logic [SLOT_W-1:0] wr_slot;
   logic              wr_gnt;
   logic              rd_req;
   logic [SLOT_W-1:0] rd_slot;
   logic              rd_gnt;
   logic              mlb_read_en;
   logic              mlb_write_en;
   logic [SLOT_W-1:0] mlb_sel_pe;
   logic              rd_data_valid;
   logic [SLOT_W-1:0] rd_data_slot;

   modport master (
      output wr_req, wr_slot, rd_req, rd_slot,
      input  wr_gnt, rd_gnt, mlb_read_en, mlb_write_en, mlb_sel_pe,
             rd_data_valid, rd_data_slot
   );

   modport slave (
      input  wr_req, wr_slot, rd_req, rd_slot,
      output wr_gnt, rd_gnt, mlb_read_en, mlb_write_en, mlb_sel_pe,
             rd_data_valid, rd_data_slot
   );

endinterface

// File: rtl/mlb_rr_arb.sv
// Two-requester round-robin arbiter; preference flips only on contended cycles.
module mlb_rr_arb
   import mlb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rd_elig,
   input  logic wr_elig,
   output acc_t gnt
);

   acc_t pref;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pref <= ACC_RD;
      end else if (rd_elig && wr_elig) begin
         pref <= (pref == ACC_RD) ? ACC_WR : ACC_RD;
      end
   end

   always_comb begin
      gnt = ACC_NONE;
      if (rd_elig && wr_elig) begin
         gnt = pref;
      end else if (rd_elig) begin
         gnt = ACC_RD;
      end else if (wr_elig) begin
         gnt = ACC_WR;
      end
   end

endmodule

// File: rtl/mlb_ctrl.sv
// MLB port arbiter, occupancy scoreboard and in-order drain sequencer.
// Optional performance counters are enabled by defining MLB_CTRL_PERF_EN.
module mlb_ctrl
   import mlb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   mlb_ctrl_if.slave            bus,
   input  logic                 seq_start,
   input  logic [SLOT_W:0]      seq_len,
   output logic                 seq_busy,
   output logic                 seq_done,
   input  logic                 flush,
   output logic [NUM_SLOTS-1:0] slot_valid,
   output logic                 full,
   output logic                 empty
`ifdef MLB_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]     perf_wr_cnt,
   output logic [CNT_W-1:0]     perf_rd_cnt,
   output logic [CNT_W-1:0]     perf_stall_cnt
`endif
);

   seq_state_t        state, state_nxt;
   logic [SLOT_W-1:0] idx, idx_nxt;
   logic [SLOT_W-1:0] last_idx, last_idx_nxt;
   logic [SLOT_W-1:0] rd_sel;
   logic              rd_elig;
   logic              wr_elig;
   acc_t              gnt;

   // Flush masks both eligibilities so the arbiter neither grants nor flips preference.
   always_comb begin
      rd_sel  = (state == SEQ) ? idx : bus.rd_slot;
      rd_elig = 1'b0;
      if (!flush) begin
         if (state == SEQ) begin
            rd_elig = slot_valid[idx];
         end else if (state == IDLE) begin
            rd_elig = bus.rd_req && slot_valid[bus.rd_slot];
         end
      end
      wr_elig = !flush && bus.wr_req && !slot_valid[bus.wr_slot];
   end

   mlb_rr_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .rd_elig (rd_elig),
      .wr_elig (wr_elig),
      .gnt     (gnt)
   );

   always_comb begin
      bus.rd_gnt       = (gnt == ACC_RD);
      bus.wr_gnt       = (gnt == ACC_WR);
      bus.mlb_read_en  = (gnt == ACC_RD);
      bus.mlb_write_en = (gnt == ACC_WR);
      case (gnt)
         ACC_RD:  bus.mlb_sel_pe = rd_sel;
         ACC_WR:  bus.mlb_sel_pe = bus.wr_slot;
         default: bus.mlb_sel_pe = '0;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      last_idx_nxt = last_idx;
      seq_busy     = 1'b0;
      seq_done     = 1'b0;
      case (state)
         IDLE: begin
            if (seq_start) begin
               if (seq_len != '0) begin
                  state_nxt    = SEQ;
                  idx_nxt      = '0;
                  last_idx_nxt = SLOT_W'(seq_len - 1'b1);
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         SEQ: begin
            seq_busy = 1'b1;
            if (bus.rd_gnt) begin
               if (idx == last_idx) begin
                  state_nxt = DONE;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         DONE: begin
            seq_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         seq_busy  = 1'b0;
         seq_done  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         idx      <= '0;
         last_idx <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         last_idx <= last_idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_valid <= '0;
      end else if (flush) begin
         slot_valid <= '0;
      end else begin
         if (bus.wr_gnt) slot_valid[bus.wr_slot] <= 1'b1;
         if (bus.rd_gnt) slot_valid[rd_sel]      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rd_data_valid <= 1'b0;
         bus.rd_data_slot  <= '0;
      end else begin
         bus.rd_data_valid <= bus.rd_gnt;
         bus.rd_data_slot  <= bus.rd_gnt ? rd_sel : '0;
      end
   end

   assign full  = &slot_valid;
   assign empty = ~|slot_valid;

`ifdef MLB_CTRL_PERF_EN
   logic req_present;
   assign req_present = bus.wr_req || bus.rd_req || (state == SEQ);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_wr_cnt    <= '0;
         perf_rd_cnt    <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (bus.wr_gnt && perf_wr_cnt != '1) perf_wr_cnt <= perf_wr_cnt + 1'b1;
         if (bus.rd_gnt && perf_rd_cnt != '1) perf_rd_cnt <= perf_rd_cnt + 1'b1;
         if (req_present && gnt == ACC_NONE && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mlb_ctrl.sv
// Directed self-checking bench for mlb_ctrl (perf counters checked when MLB_CTRL_PERF_EN is defined).
module tb_mlb_ctrl;
   import mlb_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 seq_start;
   logic [SLOT_W:0]      seq_len;
   logic                 seq_busy;
   logic                 seq_done;
   logic                 flush;
   logic [NUM_SLOTS-1:0] slot_valid;
   logic                 full;
   logic                 empty;
`ifdef MLB_CTRL_PERF_EN
   logic [CNT_W-1:0]     perf_wr_cnt;
   logic [CNT_W-1:0]     perf_rd_cnt;
   logic [CNT_W-1:0]     perf_stall_cnt;
`endif

   int errors;
   int checks;

   mlb_ctrl_if bus ();

   mlb_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .seq_start  (seq_start),
      .seq_len    (seq_len),
      .seq_busy   (seq_busy),
      .seq_done   (seq_done),
      .flush      (flush),
      .slot_valid (slot_valid),
      .full       (full),
      .empty      (empty)
`ifdef MLB_CTRL_PERF_EN
      ,
      .perf_wr_cnt    (perf_wr_cnt),
      .perf_rd_cnt    (perf_rd_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (slot_valid !== '0) begin errors++; $display("FAIL reset_slot_valid: got %h want 0", slot_valid); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.mlb_read_en, bus.mlb_write_en} !== 4'b0) begin
         errors++; $display("FAIL reset_grants: got %b want 0000", {bus.wr_gnt, bus.rd_gnt, bus.mlb_read_en, bus.mlb_write_en}); end
      checks++; if ({seq_busy, seq_done, bus.rd_data_valid} !== 3'b0) begin
         errors++; $display("FAIL reset_seq: got %b want 000", {seq_busy, seq_done, bus.rd_data_valid}); end
      checks++; if (bus.mlb_sel_pe !== '0 || bus.rd_data_slot !== '0) begin
         errors++; $display("FAIL reset_sel: got %0d/%0d want 0/0", bus.mlb_sel_pe, bus.rd_data_slot); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_write();
      bus.wr_req = 1'b1; bus.wr_slot = 5'd3;
      #1;
      checks++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL wr3_gnt: got %b want 1", bus.wr_gnt); end
      checks++; if ({bus.mlb_write_en, bus.mlb_read_en} !== 2'b10) begin
         errors++; $display("FAIL wr3_en: got %b want 10", {bus.mlb_write_en, bus.mlb_read_en}); end
      checks++; if (bus.mlb_sel_pe !== 5'd3) begin errors++; $display("FAIL wr3_sel: got %0d want 3", bus.mlb_sel_pe); end
      tick();
      bus.wr_req = 1'b0;
      #1;
      checks++; if (slot_valid !== 32'h8) begin errors++; $display("FAIL wr3_valid: got %h want 00000008", slot_valid); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL wr3_empty: got %b want 0", empty); end
   endtask

   task automatic test_blocked_write();
      bus.wr_req = 1'b1; bus.wr_slot = 5'd5;
      #1;
      checks++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL wr5_first: got %b want 1", bus.wr_gnt); end
      tick();
      #1;
      checks++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL wr5_blocked: got %b want 0", bus.wr_gnt); end
      tick();
      bus.rd_req = 1'b1; bus.rd_slot = 5'd5;
      #1;
      checks++; if ({bus.rd_gnt, bus.wr_gnt} !== 2'b10) begin
         errors++; $display("FAIL rd5_gnt: got rd/wr %b want 10", {bus.rd_gnt, bus.wr_gnt}); end
      checks++; if ({bus.mlb_read_en, bus.mlb_write_en} !== 2'b10 || bus.mlb_sel_pe !== 5'd5) begin
         errors++; $display("FAIL rd5_drive: got en %b sel %0d want 10 sel 5", {bus.mlb_read_en, bus.mlb_write_en}, bus.mlb_sel_pe); end
      tick();
      bus.rd_req = 1'b0;
      #1;
      checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data_slot !== 5'd5) begin
         errors++; $display("FAIL rd5_data: got v=%b slot=%0d want v=1 slot=5", bus.rd_data_valid, bus.rd_data_slot); end
      checks++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL wr5_after_rd: got %b want 1", bus.wr_gnt); end
      tick();
      bus.wr_req = 1'b0;
      #1;
      checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL rd5_data_pulse: got %b want 0", bus.rd_data_valid); end
      checks++; if (slot_valid !== 32'h28) begin errors++; $display("FAIL wr5_valid: got %h want 00000028", slot_valid); end
   endtask

   task automatic test_round_robin();
      int unsigned rs[4] = '{1, 2, 2, 3};
      int unsigned ws[4] = '{0, 0, 1, 1};
      logic        exp_rd[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [SLOT_W-1:0] exp_sel;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.wr_req = 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         bus.wr_slot = SLOT_W'(i);
         tick();
      end
      bus.wr_req = 1'b0;
      #1;
      checks++; if (full !== 1'b1 || slot_valid !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL fill_full: got full=%b valid=%h want 1 ffffffff", full, slot_valid); end
      bus.rd_req = 1'b1; bus.rd_slot = 5'd0;
      tick();
      bus.wr_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.rd_slot = SLOT_W'(rs[i]);
         bus.wr_slot = SLOT_W'(ws[i]);
         exp_sel = exp_rd[i] ? SLOT_W'(rs[i]) : SLOT_W'(ws[i]);
         #1;
         checks++; if ({bus.rd_gnt, bus.wr_gnt} !== {exp_rd[i], ~exp_rd[i]} || bus.mlb_sel_pe !== exp_sel) begin
            errors++; $display("FAIL rr_cycle%0d: got rd/wr %b sel %0d want %b sel %0d",
                               i, {bus.rd_gnt, bus.wr_gnt}, bus.mlb_sel_pe, {exp_rd[i], ~exp_rd[i]}, exp_sel); end
         tick();
      end
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      #1;
      checks++; if (slot_valid !== 32'hFFFF_FFFB || full !== 1'b0) begin
         errors++; $display("FAIL rr_valid: got %h full=%b want fffffffb full=0", slot_valid, full); end
   endtask

   task automatic test_sequencer();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.wr_req = 1'b1;
      bus.wr_slot = 5'd0; tick();
      bus.wr_slot = 5'd1; tick();
      bus.wr_slot = 5'd3; tick();
      bus.wr_req = 1'b0;
      seq_start = 1'b1; seq_len = 6'd3;
      #1;
      checks++; if (seq_busy !== 1'b0 || bus.rd_gnt !== 1'b0) begin
         errors++; $display("FAIL seq_start_cycle: got busy=%b rd_gnt=%b want 0 0", seq_busy, bus.rd_gnt); end
      tick();
      seq_start = 1'b0;
      #1;
      checks++; if (seq_busy !== 1'b1 || bus.rd_gnt !== 1'b1 || bus.mlb_sel_pe !== 5'd0) begin
         errors++; $display("FAIL seq_rd0: got busy=%b gnt=%b sel=%0d want 1 1 0", seq_busy, bus.rd_gnt, bus.mlb_sel_pe); end
      tick();
      #1;
      checks++; if (bus.rd_gnt !== 1'b1 || bus.mlb_sel_pe !== 5'd1) begin
         errors++; $display("FAIL seq_rd1: got gnt=%b sel=%0d want 1 1", bus.rd_gnt, bus.mlb_sel_pe); end
      tick();
      bus.rd_req = 1'b1; bus.rd_slot = 5'd3;
      #1;
      checks++; if (bus.rd_gnt !== 1'b0 || seq_busy !== 1'b1) begin
         errors++; $display("FAIL seq_stall2: got gnt=%b busy=%b want 0 1", bus.rd_gnt, seq_busy); end
      checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data_slot !== 5'd1) begin
         errors++; $display("FAIL seq_data1: got v=%b slot=%0d want 1 1", bus.rd_data_valid, bus.rd_data_slot); end
      tick();
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b1; bus.wr_slot = 5'd2;
      #1;
      checks++; if (bus.wr_gnt !== 1'b1 || bus.rd_gnt !== 1'b0) begin
         errors++; $display("FAIL seq_wr2: got wr=%b rd=%b want 1 0", bus.wr_gnt, bus.rd_gnt); end
      tick();
      bus.wr_req = 1'b0;
      #1;
      checks++; if (bus.rd_gnt !== 1'b1 || bus.mlb_sel_pe !== 5'd2) begin
         errors++; $display("FAIL seq_rd2: got gnt=%b sel=%0d want 1 2", bus.rd_gnt, bus.mlb_sel_pe); end
      tick();
      #1;
      checks++; if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
         errors++; $display("FAIL seq_done_pulse: got done=%b busy=%b want 1 0", seq_done, seq_busy); end
      checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data_slot !== 5'd2) begin
         errors++; $display("FAIL seq_data2: got v=%b slot=%0d want 1 2", bus.rd_data_valid, bus.rd_data_slot); end
      tick();
      #1;
      checks++; if (seq_done !== 1'b0 || slot_valid !== 32'h8) begin
         errors++; $display("FAIL seq_end: got done=%b valid=%h want 0 00000008", seq_done, slot_valid); end
   endtask

   task automatic test_flush();
      bus.wr_req = 1'b1;
      bus.wr_slot = 5'd0; tick();
      bus.wr_slot = 5'd1; tick();
      bus.wr_req = 1'b0;
      seq_start = 1'b1; seq_len = 6'd3;
      tick();
      seq_start = 1'b0;
      #1;
      checks++; if (bus.rd_gnt !== 1'b1 || bus.mlb_sel_pe !== 5'd0) begin
         errors++; $display("FAIL flush_pre_rd0: got gnt=%b sel=%0d want 1 0", bus.rd_gnt, bus.mlb_sel_pe); end
      tick();
      flush = 1'b1;
      bus.wr_req = 1'b1; bus.wr_slot = 5'd5;
      #1;
      checks++; if ({bus.rd_gnt, bus.wr_gnt, bus.mlb_read_en, bus.mlb_write_en} !== 4'b0) begin
         errors++; $display("FAIL flush_no_gnt: got %b want 0000", {bus.rd_gnt, bus.wr_gnt, bus.mlb_read_en, bus.mlb_write_en}); end
      checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data_slot !== 5'd0) begin
         errors++; $display("FAIL flush_pending_data: got v=%b slot=%0d want 1 0", bus.rd_data_valid, bus.rd_data_slot); end
      tick();
      flush = 1'b0; bus.wr_req = 1'b0;
      #1;
      checks++; if (slot_valid !== '0 || empty !== 1'b1) begin
         errors++; $display("FAIL flush_clear: got valid=%h empty=%b want 0 1", slot_valid, empty); end
      checks++; if ({seq_busy, seq_done, bus.rd_data_valid} !== 3'b0) begin
         errors++; $display("FAIL flush_fsm: got busy/done/dv %b want 000", {seq_busy, seq_done, bus.rd_data_valid}); end
      tick();
      checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b want 0", seq_done); end
      seq_start = 1'b1; seq_len = 6'd0;
      tick();
      seq_start = 1'b0;
      #1;
      checks++; if (seq_done !== 1'b1 || seq_busy !== 1'b0 || bus.rd_gnt !== 1'b0) begin
         errors++; $display("FAIL len0_done: got done=%b busy=%b gnt=%b want 1 0 0", seq_done, seq_busy, bus.rd_gnt); end
      tick();
      checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL len0_pulse: got %b want 0", seq_done); end
   endtask

   task automatic test_reset_mid_seq();
      bus.wr_req = 1'b1; bus.wr_slot = 5'd0;
      tick();
      bus.wr_req = 1'b0;
      seq_start = 1'b1; seq_len = 6'd2;
      tick();
      seq_start = 1'b0;
      #1;
      checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL rstseq_busy: got %b want 1", seq_busy); end
      rst = 1'b0;
      #1;
      checks++; if (seq_busy !== 1'b0 || slot_valid !== '0 || bus.rd_gnt !== 1'b0 || empty !== 1'b1) begin
         errors++; $display("FAIL rstseq_async: got busy=%b valid=%h gnt=%b empty=%b want 0 0 0 1",
                            seq_busy, slot_valid, bus.rd_gnt, empty); end
      tick();
      rst = 1'b1;
      tick();
   endtask

`ifdef MLB_CTRL_PERF_EN
   task automatic test_perf();
      checks++; if ({perf_wr_cnt, perf_rd_cnt, perf_stall_cnt} !== '0) begin
         errors++; $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", perf_wr_cnt, perf_rd_cnt, perf_stall_cnt); end
      bus.wr_req = 1'b1;
      bus.wr_slot = 5'd0; tick();
      bus.wr_slot = 5'd1; tick();
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b1; bus.rd_slot = 5'd0; tick();
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b1; bus.wr_slot = 5'd1;
      repeat (3) tick();
      bus.wr_req = 1'b0;
      #1;
      checks++; if (perf_wr_cnt !== 16'd2 || perf_rd_cnt !== 16'd1 || perf_stall_cnt !== 16'd3) begin
         errors++; $display("FAIL perf_count: got %0d/%0d/%0d want 2/1/3", perf_wr_cnt, perf_rd_cnt, perf_stall_cnt); end
      flush = 1'b1; tick(); flush = 1'b0;
      #1;
      checks++; if (perf_wr_cnt !== 16'd2 || perf_rd_cnt !== 16'd1 || perf_stall_cnt !== 16'd3) begin
         errors++; $display("FAIL perf_flush_hold: got %0d/%0d/%0d want 2/1/3", perf_wr_cnt, perf_rd_cnt, perf_stall_cnt); end
      rst = 1'b0;
      #1;
      checks++; if ({perf_wr_cnt, perf_rd_cnt, perf_stall_cnt} !== '0) begin
         errors++; $display("FAIL perf_rst_clear: got %0d/%0d/%0d want 0/0/0", perf_wr_cnt, perf_rd_cnt, perf_stall_cnt); end
      tick();
      rst = 1'b1;
      tick();
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      flush = 1'b0;
      seq_start = 1'b0;
      seq_len = '0;
      bus.wr_req = 1'b0;
      bus.wr_slot = '0;
      bus.rd_req = 1'b0;
      bus.rd_slot = '0;
      test_reset();
      test_write();
      test_blocked_write();
      test_round_robin();
      test_sequencer();
      test_flush();
      test_reset_mid_seq();
`ifdef MLB_CTRL_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish before 200000");
      $fatal(1);
   end

endmodule
